// File: rtl/snoopy_pkg.sv
// Shared constants for Snoopy's movement path: FSM state encodings, owner codes,
// playfield limits, frame-rate defaults and the left/right resolution helper.
package snoopy_pkg;

   localparam logic [1:0] S_PAUSED = 2'd0;
   localparam logic [1:0] S_PLAYER = 2'd1;
   localparam logic [1:0] S_DEMO   = 2'd2;

   localparam logic OWNER_PLAYER = 1'b0;
   localparam logic OWNER_DEMO   = 1'b1;

   localparam int MAX_X_POS = 160;

   localparam int CLK_HZ              = 50_000_000;
   localparam int FRAME_HZ            = 60;
   localparam int TICK_DIV_DEFAULT    = 833_334;
   localparam int CNT_W_DEFAULT       = 20;
   localparam int IDLE_FRAMES_DEFAULT = 600;

   typedef struct packed {
      logic left;
      logic right;
   } move_t;

   // Opposing requests cancel, so left and right can never both be driven.
   function automatic move_t resolve_dir(input logic req_left, input logic req_right);
      move_t dir;
      dir.left  = req_left & ~req_right;
      dir.right = req_right & ~req_left;
      return dir;
   endfunction

endpackage

// File: rtl/snoopy_frame_tick.sv
// Frame divider: counts 0..TICK_DIV-1 while run is high and pulses frame_tick on the
// last count. The count is frozen (not cleared) while paused so a frame resumes mid-way.
module snoopy_frame_tick #(
   parameter int TICK_DIV = 833_334,
   parameter int CNT_W    = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic frame_tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             at_last;

   assign at_last    = (count_q == LAST_CNT);
   assign frame_tick = run & at_last;

   always_comb begin
      count_d = count_q;
      if (run) begin
         if (at_last) begin
            count_d = '0;
         end else begin
            count_d = count_q + ONE_CNT;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/snoopy_move_scheduler.sv
// Frame-rate scheduler for Snoopy's horizontal movement: arbitrates player and demo
// commands and issues one registered left/right command per frame. SNOOPY_DEMO_EN adds demo ownership.
//
//   state    | meaning
//   S_PAUSED | run low; no movement, player owns
//   S_PLAYER | keyboard drives move_* at each frame tick; idle frames counted
//   S_DEMO   | demo source drives move_*; any key press hands control back
module snoopy_move_scheduler
   import snoopy_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int IDLE_FRAMES = IDLE_FRAMES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic kbd_left,
   input  logic kbd_right,
   input  logic demo_valid,
   input  logic demo_left,
   input  logic demo_right,
   output logic demo_ready,
   output logic move_left,
   output logic move_right,
   output logic frame_tick,
   output logic owner
);

   logic [1:0] state_q, state_d;
   move_t      move_q, move_d;
   move_t      kbd_dir;

   snoopy_frame_tick #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_frame_tick (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .frame_tick (frame_tick)
   );

   assign kbd_dir    = resolve_dir(kbd_left, kbd_right);
   assign move_left  = move_q.left;
   assign move_right = move_q.right;

`ifdef SNOOPY_DEMO_EN
   localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_FRAMES);

   logic [15:0] idle_q, idle_d;
   logic        kbd_any;
   logic        demo_take;
   move_t       demo_dir;

   assign kbd_any  = kbd_left | kbd_right;
   assign demo_dir = resolve_dir(demo_left, demo_right);

   always_comb begin
      state_d   = state_q;
      move_d    = move_q;
      idle_d    = idle_q;
      demo_take = 1'b0;
      if (!run) begin
         state_d = S_PAUSED;
         move_d  = '0;
      end else begin
         case (state_q)
            S_PAUSED: begin
               state_d = S_PLAYER;
               idle_d  = '0;
            end
            S_PLAYER: begin
               if (frame_tick) begin
                  move_d = kbd_dir;
                  if (kbd_any) begin
                     idle_d = '0;
                  end else if (idle_q >= IDLE_LIMIT - 16'd1) begin
                     // Hand-over frame carries no movement; idle saturates at the limit.
                     idle_d  = IDLE_LIMIT;
                     state_d = S_DEMO;
                     move_d  = '0;
                  end else begin
                     idle_d = idle_q + 16'd1;
                  end
               end
            end
            S_DEMO: begin
               if (kbd_any) begin
                  state_d = S_PLAYER;
                  idle_d  = '0;
                  move_d  = '0;
               end else if (frame_tick) begin
                  if (demo_valid) begin
                     demo_take = 1'b1;
                     move_d    = demo_dir;
                  end else begin
                     move_d = '0;
                  end
               end
            end
            default: begin
               state_d = S_PAUSED;
               move_d  = '0;
            end
         endcase
      end
   end

   // A command offered during reset is not consumed, since its move would be discarded.
   assign demo_ready = demo_take & ~reset;
   assign owner      = (state_q == S_DEMO) ? OWNER_DEMO : OWNER_PLAYER;

   always_ff @(posedge clock) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   localparam int unused_idle_frames = IDLE_FRAMES;

   logic unused_demo;

   assign unused_demo = ^{demo_valid, demo_left, demo_right};

   always_comb begin
      state_d = state_q;
      move_d  = move_q;
      if (!run) begin
         state_d = S_PAUSED;
         move_d  = '0;
      end else begin
         case (state_q)
            S_PAUSED: state_d = S_PLAYER;
            S_PLAYER: begin
               if (frame_tick) begin
                  move_d = kbd_dir;
               end
            end
            default: begin
               state_d = S_PAUSED;
               move_d  = '0;
            end
         endcase
      end
   end

   assign demo_ready = 1'b0;
   assign owner      = OWNER_PLAYER;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_PAUSED;
         move_q  <= '0;
      end else begin
         state_q <= state_d;
         move_q  <= move_d;
      end
   end

endmodule

// File: tb/tb_snoopy_move_scheduler.sv
// Self-checking bench for snoopy_move_scheduler (TICK_DIV=4, IDLE_FRAMES=3): directed
// steps followed by random traffic, all compared with a frame-level reference model.
module tb_snoopy_move_scheduler;

   localparam int TICK_DIV    = 4;
   localparam int IDLE_FRAMES = 3;
`ifdef SNOOPY_DEMO_EN
   localparam bit DEMO_EN = 1'b1;
`else
   localparam bit DEMO_EN = 1'b0;
`endif

   localparam int M_PAUSED = 0;
   localparam int M_PLAYER = 1;
   localparam int M_DEMO   = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b0;
   logic kbd_left = 1'b0, kbd_right = 1'b0;
   logic demo_valid = 1'b0, demo_left = 1'b0, demo_right = 1'b0;
   logic demo_ready, move_left, move_right, frame_tick, owner;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: position inside the frame, who owns movement, idle frame count.
   bit m_known = 1'b0;
   int m_phase = 0;
   int m_mode = M_PAUSED;
   int m_idle = 0;
   bit m_ml = 1'b0, m_mr = 1'b0;

   snoopy_move_scheduler #(
      .TICK_DIV    (TICK_DIV),
      .CNT_W       (20),
      .IDLE_FRAMES (IDLE_FRAMES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .kbd_left   (kbd_left),
      .kbd_right  (kbd_right),
      .demo_valid (demo_valid),
      .demo_left  (demo_left),
      .demo_right (demo_right),
      .demo_ready (demo_ready),
      .move_left  (move_left),
      .move_right (move_right),
      .frame_tick (frame_tick),
      .owner      (owner)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic rs, input logic r, input logic kl, input logic kr,
                       input logic dv, input logic dl, input logic dr);
      bit tick_e, rdy_e, key;
      int n_phase, n_mode, n_idle;
      bit n_ml, n_mr;
      @(negedge clock);
      reset = rs; run = r; kbd_left = kl; kbd_right = kr;
      demo_valid = dv; demo_left = dl; demo_right = dr;
      #1;
      key    = kl || kr;
      tick_e = r && (m_phase == TICK_DIV - 1);
      rdy_e  = DEMO_EN && !rs && (m_mode == M_DEMO) && tick_e && dv && !key;
      if (m_known) begin
         chk("frame_tick", frame_tick, tick_e);
         chk("demo_ready", demo_ready, rdy_e);
         chk("move_left", move_left, m_ml);
         chk("move_right", move_right, m_mr);
         chk("owner", owner, m_mode == M_DEMO);
         chk("move_exclusive", move_left & move_right, 1'b0);
      end
      n_phase = r ? (m_phase + 1) % TICK_DIV : m_phase;
      n_mode = m_mode; n_idle = m_idle; n_ml = m_ml; n_mr = m_mr;
      if (!r) begin
         n_mode = M_PAUSED; n_ml = 0; n_mr = 0;
      end else if (m_mode == M_PAUSED) begin
         n_mode = M_PLAYER; n_idle = 0;
      end else if (m_mode == M_PLAYER) begin
         if (tick_e) begin
            n_ml = kl && !kr;
            n_mr = kr && !kl;
            if (DEMO_EN) begin
               n_idle = key ? 0 : ((m_idle + 1 > IDLE_FRAMES) ? IDLE_FRAMES : m_idle + 1);
               if (n_idle == IDLE_FRAMES) begin
                  n_mode = M_DEMO; n_ml = 0; n_mr = 0;
               end
            end
         end
      end else begin
         if (key) begin
            n_mode = M_PLAYER; n_idle = 0; n_ml = 0; n_mr = 0;
         end else if (tick_e) begin
            n_ml = dv && dl && !dr;
            n_mr = dv && dr && !dl;
         end
      end
      @(posedge clock);
      #1;
      if (rs) begin
         m_known = 1'b1;
         m_phase = 0; m_mode = M_PAUSED; m_idle = 0; m_ml = 0; m_mr = 0;
      end else begin
         m_phase = n_phase; m_mode = n_mode; m_idle = n_idle; m_ml = n_ml; m_mr = n_mr;
      end
   endtask

   initial begin
      // Reset, then idle outputs.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // Run with right held: first tick four cycles in, move_right the cycle after.
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 0, 0);
      chk("right_after_tick", move_right, 1'b1);
      // Both keys across a tick cancel.
      for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 0, 0);
      chk("both_cancel", move_left | move_right, 1'b0);
      // No keys for enough frames to hand over, then demo left.
      for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 1, 0);
      // Key press mid-frame returns control to the player.
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 1, 1, 0);
      // Drop run mid-frame, stay paused, resume.
      step(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 0, 0);
      // Ten idle frames with demo traffic offered.
      for (int i = 0; i < 10 * TICK_DIV; i++) step(0, 1, 0, 0, 1, i[0], ~i[0]);
      // Reset in the middle of a frame.
      step(0, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0);
      // Random traffic, keys sparse so the demo regularly takes over.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 399) == 0,
              $urandom_range(0, 19) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) != 0,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
